// File: rtl/program_counter_ras_if.sv
// Fetch-control bus between decoder/register file and the PC generator.
// The package carries the branch-condition encoding and status flag positions
// shared by both sides of the bus.

package program_counter_ras_pkg;

  typedef enum logic [2:0] {
    ZERO             = 3'd0,
    NOT_ZERO         = 3'd1,
    NEGATIVE         = 3'd2,
    POSITIVE         = 3'd3,
    CARRY_SET        = 3'd4,
    CARRY_CLEARED    = 3'd5,
    OVERFLOW_SET     = 3'd6,
    OVERFLOW_CLEARED = 3'd7
  } branch_condition_e;

  localparam int ZERO_FLAG     = 0;
  localparam int POSITIVE_FLAG = 1;
  localparam int CARRY_FLAG    = 2;
  localparam int OVERFLOW_FLAG = 3;

endpackage

interface program_counter_ras_if #(
  parameter int I_ADDR_W = 12,
  parameter int DATA_W   = 8
);

  logic                                  stall;
  logic [I_ADDR_W-1:0]                   imar;
  logic [I_ADDR_W-1:0]                   address_immediate;
  logic                                  jump_branch_select;
  logic                                  immediate_select;
  logic                                  unconditional_branch;
  logic                                  pc_relative;
  logic [DATA_W-1:0]                     status_register;
  program_counter_ras_pkg::branch_condition_e branch_condition;
  logic                                  call;
  logic                                  ret;
  logic [I_ADDR_W-1:0]                   pc;
  logic                                  branch_taken;

  // Decoder side: drives control, observes the fetch address.
  modport master (
    output stall, imar, address_immediate, jump_branch_select, immediate_select,
           unconditional_branch, pc_relative, status_register, branch_condition,
           call, ret,
    input  pc, branch_taken
  );

  // PC generator side.
  modport slave (
    input  stall, imar, address_immediate, jump_branch_select, immediate_select,
           unconditional_branch, pc_relative, status_register, branch_condition,
           call, ret,
    output pc, branch_taken
  );

endinterface

// File: rtl/program_counter_ras.sv
// Instruction fetch address generator with return-address stack.
// Next PC is chosen from debug load, return, taken branch/call or sequential
// increment. The RAS is a circular buffer: pushing when full silently drops
// the oldest entry, popping when empty leaves the pointer alone. All state is
// registered; only branch_taken is combinational.

module program_counter_ras
  import program_counter_ras_pkg::*;
#(
  parameter int                  I_ADDR_W     = 12,
  parameter int                  INST_W_BYTES = 2,
  parameter int                  DATA_W       = 8,
  parameter int                  RAS_DEPTH    = 4,
  parameter logic [I_ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  program_counter_ras_if.slave           bus,
  input  logic                           debug_enable,
  input  logic                           debug_step,
  input  logic                           debug_pc_load,
  input  logic [I_ADDR_W-1:0]            debug_pc_value,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  localparam logic [I_ADDR_W-1:0] PC_INC   = I_ADDR_W'(INST_W_BYTES);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(RAS_DEPTH - 1);

  // Circular pointer helpers; explicit wrap keeps non-power-of-two depths legal.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_LAST) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == '0) begin
      r = PTR_LAST;
    end else begin
      r = p - PTR_W'(1);
    end
    return r;
  endfunction

  // State
  logic [I_ADDR_W-1:0] pc_r;
  logic [I_ADDR_W-1:0] ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0]    top_r;
  logic [CNT_W-1:0]    count_r;
  logic                overflow_r;
  logic                underflow_r;
  logic                step_q_r;

  // Next-state
  logic [I_ADDR_W-1:0] pc_next_s;
  logic [PTR_W-1:0]    top_next_s;
  logic [CNT_W-1:0]    count_next_s;
  logic                overflow_next_s;
  logic                underflow_next_s;
  logic                push_s;

  // Decode helpers
  logic                step_edge_s;
  logic                advance_s;
  logic                load_s;
  logic                cond_s;
  logic                taken_s;
  logic                call_ok_s;
  logic [I_ADDR_W-1:0] seq_pc_s;
  logic [I_ADDR_W-1:0] target_s;
  logic [I_ADDR_W-1:0] offset_s;
  logic [I_ADDR_W-1:0] base_s;

  // Upper status bits carry no meaning for the fetch unit.
  logic unused_status_s;
  assign unused_status_s = ^bus.status_register[DATA_W-1:4];

  assign step_edge_s = debug_step & ~step_q_r;
  assign advance_s   = ~bus.stall & (~debug_enable | step_edge_s);
  assign load_s      = debug_enable & debug_pc_load;
  assign call_ok_s   = bus.call & bus.jump_branch_select & bus.unconditional_branch;
  assign seq_pc_s    = pc_r + PC_INC;

  // Resolve the condition code against the status flags and qualify it.
  always_comb begin
    cond_s = 1'b0;
    case (bus.branch_condition)
      ZERO:             cond_s =  bus.status_register[ZERO_FLAG];
      NOT_ZERO:         cond_s = ~bus.status_register[ZERO_FLAG];
      NEGATIVE:         cond_s = ~bus.status_register[POSITIVE_FLAG];
      POSITIVE:         cond_s =  bus.status_register[POSITIVE_FLAG];
      CARRY_SET:        cond_s =  bus.status_register[CARRY_FLAG];
      CARRY_CLEARED:    cond_s = ~bus.status_register[CARRY_FLAG];
      OVERFLOW_SET:     cond_s =  bus.status_register[OVERFLOW_FLAG];
      OVERFLOW_CLEARED: cond_s = ~bus.status_register[OVERFLOW_FLAG];
      default:          cond_s = 1'b0;
    endcase

    taken_s = 1'b0;
    if (!bus.jump_branch_select) begin
      taken_s = 1'b0;
    end else if (bus.unconditional_branch) begin
      taken_s = 1'b1;
    end else begin
      taken_s = cond_s;
    end
  end

  // Branch target: optional PC base plus register or immediate offset, mod 2^I_ADDR_W.
  always_comb begin
    base_s = '0;
    if (bus.pc_relative) begin
      base_s = pc_r;
    end else begin
      base_s = '0;
    end

    offset_s = bus.imar;
    if (bus.immediate_select) begin
      offset_s = bus.address_immediate;
    end else begin
      offset_s = bus.imar;
    end

    target_s = base_s + offset_s;
  end

  // Next PC and RAS bookkeeping: debug load > ret > taken branch/call > sequential.
  always_comb begin
    pc_next_s        = pc_r;
    top_next_s       = top_r;
    count_next_s     = count_r;
    overflow_next_s  = overflow_r;
    underflow_next_s = underflow_r;
    push_s           = 1'b0;

    if (load_s) begin
      pc_next_s = debug_pc_value;
    end else if (advance_s) begin
      if (bus.ret) begin
        if (count_r != '0) begin
          pc_next_s    = ras_mem_r[top_r];
          top_next_s   = ptr_dec(top_r);
          count_next_s = count_r - CNT_W'(1);
        end else begin
          pc_next_s        = seq_pc_s;
          underflow_next_s = 1'b1;
        end
      end else if (taken_s) begin
        pc_next_s = target_s;
        if (call_ok_s) begin
          push_s     = 1'b1;
          top_next_s = ptr_inc(top_r);
          if (count_r == CNT_FULL) begin
            overflow_next_s = 1'b1;
          end else begin
            count_next_s = count_r + CNT_W'(1);
          end
        end else begin
          push_s = 1'b0;
        end
      end else begin
        pc_next_s = seq_pc_s;
      end
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC, pointer, occupancy and sticky flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r        <= RESET_VECTOR;
      top_r       <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      pc_r        <= pc_next_s;
      top_r       <= top_next_s;
      count_r     <= count_next_s;
      overflow_r  <= overflow_next_s;
      underflow_r <= underflow_next_s;
    end
  end

  // Return-address storage; a push writes the slot the pointer moves to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= '0;
      end
    end else if (push_s) begin
      ras_mem_r[top_next_s] <= seq_pc_s;
    end else begin
      ras_mem_r <= ras_mem_r;
    end
  end

  // Debug step history, sampled every cycle so a step seen during stall is consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q_r <= 1'b0;
    end else begin
      step_q_r <= debug_step;
    end
  end

  assign bus.pc           = pc_r;
  assign bus.branch_taken = taken_s;
  assign ras_count        = count_r;
  assign ras_overflow     = overflow_r;
  assign ras_underflow    = underflow_r;

endmodule
